// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state type.
package ahbl_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'd0;
  localparam logic [1:0] HTRANS_BUSY = 2'd1;
  localparam logic [1:0] HTRANS_NSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ  = 2'd3;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} sram_state_t;
endpackage

// File: rtl/ahbl_sram_stall_lfsr.sv
// 8-bit Galois LFSR used to inject pseudo-random extra wait states.
module ahbl_sram_stall_lfsr
  import ahbl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_lfsr
);
  logic [7:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
  end

  assign o_lfsr = r_lfsr;
endmodule

// File: rtl/ahbl_sram_responder.sv
// AHB-Lite SRAM subordinate with configurable wait states and ERROR on out-of-range.
// Define AHBL_SRAM_RAND_STALL_EN to add 0-3 LFSR-driven extra wait states per transfer.
module ahbl_sram_responder
  import ahbl_pkg::*;
#(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int DEPTH     = 64,
  parameter int NSEQ_WAIT = 1,
  parameter int SEQ_WAIT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ahbls_hready_resp,
  input  logic              ahbls_hready,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata
);
  localparam int BYTES = W_DATA / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [W_ADDR-1:0] MEM_BYTES = W_ADDR'(DEPTH * BYTES);

  sram_state_t             r_state, w_state_nxt;
  logic [4:0]              r_cnt, w_cnt_nxt;
  logic                    r_pend;
  logic [OFF_W+IDX_W-1:0]  r_addr;
  logic                    r_write;
  logic [2:0]              r_size;
  logic [W_DATA-1:0]       r_mem [DEPTH];
  logic [W_DATA-1:0]       r_rdata;

  logic                    w_xfer_ok, w_cap, w_in_range, w_commit;
  logic                    w_rd_en, w_rdata_clr, w_unused;
  logic [4:0]              w_base_wait, w_cap_wait;
  logic [IDX_W-1:0]        w_cap_idx, w_idx, w_rd_idx;
  logic [BYTES-1:0]        w_strb;
  logic [W_DATA-1:0]       w_rd_word;

  assign w_xfer_ok   = ahbls_hready_resp && ahbls_hready;
  assign w_cap       = w_xfer_ok && ahbls_htrans[1];
  assign w_in_range  = ahbls_haddr < MEM_BYTES;
  assign w_cap_idx   = ahbls_haddr[OFF_W +: IDX_W];
  assign w_idx       = r_addr[OFF_W +: IDX_W];
  assign w_base_wait = ahbls_htrans[0] ? 5'(SEQ_WAIT) : 5'(NSEQ_WAIT);
  assign w_commit    = r_pend && r_write && (r_state == S_IDLE) && ahbls_hready;

`ifdef AHBL_SRAM_RAND_STALL_EN
  logic [7:0] w_lfsr;
  ahbl_sram_stall_lfsr u_lfsr (.i_clk(clk), .i_rst(rst), .o_lfsr(w_lfsr));
  assign w_cap_wait = w_base_wait + {3'b000, w_lfsr[1:0]};
  assign w_unused   = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, w_lfsr[7:2]};
`else
  assign w_cap_wait = w_base_wait;
  assign w_unused   = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock};
`endif

  // Lane b is enabled when it falls in the same size-aligned block as the address.
  always_comb begin
    w_strb = '0;
    for (int b = 0; b < BYTES; b++)
      w_strb[b] = (32'(b) >> r_size) == (32'(r_addr[OFF_W-1:0]) >> r_size);
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = HRESP_OKAY;
    w_rd_en           = 1'b0;
    w_rd_idx          = w_idx;
    w_rdata_clr       = 1'b0;
    case (r_state)
      S_WAIT: begin
        ahbls_hready_resp = 1'b0;
        w_cnt_nxt         = r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          w_state_nxt = S_IDLE;
          w_rd_en     = !r_write;
        end
      end
      S_ERR1: begin
        ahbls_hready_resp = 1'b0;
        ahbls_hresp       = HRESP_ERROR;
        w_state_nxt       = S_ERR2;
      end
      S_ERR2:  ahbls_hresp = HRESP_ERROR;
      default: ;
    endcase
    if (ahbls_hready_resp && ahbls_hready) begin
      w_state_nxt = S_IDLE;
      if (ahbls_htrans[1]) begin
        if (!w_in_range) begin
          w_state_nxt = S_ERR1;
          w_rdata_clr = !ahbls_hwrite;
        end else if (w_cap_wait != 5'd0) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_cap_wait;
        end else begin
          w_rd_en  = !ahbls_hwrite;
          w_rd_idx = w_cap_idx;
        end
      end
    end
  end

  // A read landing on the edge that commits a write to the same word sees the new bytes.
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    for (int b = 0; b < BYTES; b++)
      if (w_commit && w_strb[b] && (w_idx == w_rd_idx))
        w_rd_word[8*b +: 8] = ahbls_hwdata[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst && w_commit)
      for (int b = 0; b < BYTES; b++)
        if (w_strb[b]) r_mem[w_idx][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_xfer_ok) r_pend <= w_cap && w_in_range;
      if (w_cap) begin
        r_addr  <= ahbls_haddr[OFF_W+IDX_W-1:0];
        r_write <= ahbls_hwrite;
        r_size  <= ahbls_hsize;
      end
      if (w_rd_en)          r_rdata <= w_rd_word;
      else if (w_rdata_clr) r_rdata <= '0;
    end
  end

  assign ahbls_hrdata = r_rdata;
endmodule

// File: tb/tb_ahbl_sram_responder.sv
// Directed bench: two responders (NSEQ_WAIT=1 and NSEQ_WAIT=0) behind one bus driver with a scoreboard.
module tb_ahbl_sram_responder;
  localparam int DEPTH = 16;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [31:0] haddr  = '0;
  logic [2:0]  hsize  = 3'd2;
  logic [31:0] hwdata = '0;
  logic        sel    = 1'b0;

  logic        rdy_a, resp_a, rdy_b, resp_b;
  logic [31:0] rd_a, rd_b;
  logic [1:0]  trans_a, trans_b;
  logic        rdy, resp;
  logic [31:0] rd;

  assign trans_a = sel ? 2'b00 : htrans;
  assign trans_b = sel ? htrans : 2'b00;
  assign rdy  = sel ? rdy_b  : rdy_a;
  assign resp = sel ? resp_b : resp_a;
  assign rd   = sel ? rd_b   : rd_a;

  ahbl_sram_responder #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .NSEQ_WAIT(1), .SEQ_WAIT(0)) u_dut_a (
    .clk(clk), .rst(rst), .ahbls_hready_resp(rdy_a), .ahbls_hready(rdy_a), .ahbls_hresp(resp_a),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(trans_a), .ahbls_hsize(hsize),
    .ahbls_hburst(3'b001), .ahbls_hprot(4'b0011), .ahbls_hmastlock(1'b0),
    .ahbls_hwdata(hwdata), .ahbls_hrdata(rd_a));

  ahbl_sram_responder #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .NSEQ_WAIT(0), .SEQ_WAIT(0)) u_dut_b (
    .clk(clk), .rst(rst), .ahbls_hready_resp(rdy_b), .ahbls_hready(rdy_b), .ahbls_hresp(resp_b),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(trans_b), .ahbls_hsize(hsize),
    .ahbls_hburst(3'b001), .ahbls_hprot(4'b0011), .ahbls_hmastlock(1'b0),
    .ahbls_hwdata(hwdata), .ahbls_hrdata(rd_b));

  typedef struct {
    string       tag;
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mdl [2][64];
  logic       dp = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Runs the current data phase to completion, scoring it, then steps past the ending edge.
  task automatic finish_dphase();
    int   nwait = 0;
    bit   done  = 0;
    exp_t e;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!dp) begin
        chk("idle_rdy", {31'b0, rdy}, 32'd1);
        chk("idle_resp", {31'b0, resp}, 32'd0);
        done = 1;
      end else if (rdy !== 1'b1) begin
        nwait++;
        chk({q[0].tag, "_wait_resp"}, {31'b0, resp}, {31'b0, q[0].err});
      end else begin
        e = q.pop_front();
        chk({e.tag, "_waits"}, 32'(nwait), 32'(e.waits));
        chk({e.tag, "_resp"}, {31'b0, resp}, {31'b0, e.err});
        if (e.rd) chk({e.tag, "_rdata"}, rd, e.data);
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL timeout: data phase never completed (got hready_resp=%b want 1)", rdy);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit lane_on(input logic [2:0] sz, input logic [31:0] a, input int b);
    int n, base;
    n    = (sz >= 3'd2) ? 4 : (1 << sz);
    base = int'(a[1:0]) & ~(n - 1);
    return (b >= base) && (b < base + n);
  endfunction

  task automatic ap(input string tag, input logic [1:0] tr, input logic wr,
                    input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    exp_t e;
    int   w0;
    htrans = tr; hwrite = wr; haddr = a; hsize = sz;
    if (tr[1]) begin
      e.tag   = tag;
      e.rd    = !wr;
      e.err   = (a >= LIMIT);
      e.waits = e.err ? 1 : ((tr[0] || sel) ? 0 : 1);
      e.data  = '0;
      w0      = int'(a & ~32'h3);
      if (!e.err) begin
        for (int b = 0; b < 4; b++) begin
          if (wr && lane_on(sz, a, b)) mdl[int'(sel)][w0 + b] = wd[8*b +: 8];
          if (!wr) e.data[8*b +: 8] = mdl[int'(sel)][w0 + b];
        end
      end
      q.push_back(e);
    end
    finish_dphase();
    dp     = tr[1];
    hwdata = wd;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rdy_a", {31'b0, rdy_a}, 32'd1);
    chk("rst_resp_a", {31'b0, resp_a}, 32'd0);
    chk("rst_rdata_a", rd_a, 32'd0);
    chk("rst_rdata_b", rd_b, 32'd0);

    for (int i = 0; i < 4; i++) ap("idle", 2'd0, 1'b0, 32'h0, 3'd2, 32'h0);
    chk("idle_rdata", rd_a, 32'd0);

    ap("wr10",  2'd2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    ap("rd10",  2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
    ap("wb13",  2'd2, 1'b1, 32'h13, 3'd0, 32'hAA000000);
    ap("rd10b", 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
    ap("idle",  2'd0, 1'b0, 32'h0,  3'd2, 32'h0);
    chk("byte_merge", rd_a, 32'hAAADBEEF);

    ap("w00",  2'd2, 1'b1, 32'h00, 3'd2, 32'h11111111);
    ap("w04",  2'd3, 1'b1, 32'h04, 3'd2, 32'h22222222);
    ap("w08",  2'd3, 1'b1, 32'h08, 3'd2, 32'h33333333);
    ap("w0c",  2'd3, 1'b1, 32'h0C, 3'd2, 32'h44444444);
    ap("wh0e", 2'd2, 1'b1, 32'h0E, 3'd1, 32'hBEEF0000);
    ap("b0",   2'd2, 1'b0, 32'h00, 3'd2, 32'h0);
    ap("b1",   2'd3, 1'b0, 32'h04, 3'd2, 32'h0);
    ap("b2",   2'd3, 1'b0, 32'h08, 3'd2, 32'h0);
    ap("b3",   2'd3, 1'b0, 32'h0C, 3'd2, 32'h0);

    ap("erd",   2'd2, 1'b0, LIMIT,  3'd2, 32'h0);
    ap("ewr",   2'd2, 1'b1, 32'h40, 3'd2, 32'hFFFFFFFF);
    ap("rd00",  2'd2, 1'b0, 32'h00, 3'd2, 32'h0);
    ap("rdtop", 2'd2, 1'b0, 32'h3C, 3'd0, 32'h0);
    ap("idle",  2'd0, 1'b0, 32'h0,  3'd2, 32'h0);

    sel = 1'b1;
    ap("fw20", 2'd2, 1'b1, 32'h20, 3'd2, 32'h12345678);
    ap("fr20", 2'd2, 1'b0, 32'h20, 3'd2, 32'h0);
    ap("wc24", 2'd2, 1'b1, 32'h24, 3'd2, 32'hCAFEF00D);
    ap("wb25", 2'd2, 1'b1, 32'h25, 3'd0, 32'h0000AB00);
    ap("fr24", 2'd2, 1'b0, 32'h24, 3'd2, 32'h0);
    ap("idle", 2'd0, 1'b0, 32'h0,  3'd2, 32'h0);
    chk("fwd_merge", rd_b, 32'hCAFEAB0D);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahbl_sram_responder.md
Name: ahbl_sram_responder

Overview:
AHB-Lite subordinate memory for the downstream port of the writeback cache, i.e. the responder end of the cache's fill/spill traffic.
- Byte-addressable synchronous SRAM.
- Accepts IDLE, NSEQ and SEQ transfers.
- Inserts a configurable number of wait states.
- Gives the standard two-phase ERROR response to out-of-range accesses.
- Intended for cache system tests and bring-up, where the cache's stall tolerance and burst addressing need exercising.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width; one of 32 or 64.
- DEPTH, 64, number of W_DATA-wide words; must be a power of 2.
- NSEQ_WAIT, 1, wait states in each NSEQ data phase; range 0–15.
- SEQ_WAIT, 0, wait states in each SEQ data phase; range 0–15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ahbls_hready_resp  out  1  data-phase completion.
- ahbls_hready  in  1  global bus HREADY.
- ahbls_hresp  out  1  0=OKAY, 1=ERROR.
- ahbls_haddr  in  W_ADDR  address.
- ahbls_hwrite  in  1  write=1.
- ahbls_htrans  in  2  IDLE/BUSY/NSEQ/SEQ.
- ahbls_hsize  in  3  transfer size.
- ahbls_hburst  in  3  ignored (accepted for interface completeness).
- ahbls_hprot  in  4  ignored.
- ahbls_hmastlock  in  1  ignored.
- ahbls_hwdata  in  W_DATA  write data.
- ahbls_hrdata  out  W_DATA  read data.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Outputs: hready_resp=1, hresp=0, hrdata=0.
  - FSM to S_IDLE, wait counter to 0.
  - Memory contents retained.
  - Reset mid-transfer abandons the data phase; no write is committed.
- Address capture: on a posedge with hready=1 and htrans[1]=1, latch addr, write, size, seq=htrans[0].
  - BUSY and IDLE are not captured and get a zero-wait OKAY.
- In-range test: addr < DEPTH*W_DATA/8.
- FSM states:
  - S_IDLE: hready_resp=1, hresp=0.
  - S_WAIT: hready_resp=0; counter counts down from NSEQ_WAIT or SEQ_WAIT.
  - S_ERR1: hready_resp=0, hresp=1.
  - S_ERR2: hready_resp=1, hresp=1.
- Transitions on capture:
  - Out-of-range → S_ERR1 → S_ERR2 → S_IDLE (or straight to a new capture).
  - In-range, wait count 0 → completes in the next cycle (hready_resp=1).
  - In-range, wait count nonzero → S_WAIT for exactly that many cycles, then the completion cycle.
- Back-to-back transfers: a new address phase is captured on the completion cycle; there is no dead cycle.
- Writes:
  - Byte strobes are decoded from the latched size and addr[log2(W_DATA/8)-1:0].
  - hwdata is sampled and committed at the posedge ending the data phase (hready_resp=1).
  - Errored writes commit nothing.
- Reads:
  - hrdata is registered and valid on the cycle hready_resp=1.
  - The array is read at the posedge that ends the last wait cycle, or at the capture edge when the wait count is 0.
  - All lanes are driven with the full word; hrdata holds its value otherwise.
  - Errored reads return 0.
- Hazard: a read whose array access coincides with the commit of a write to the same word gets the written bytes forwarded, merged per strobe.
- Word index = addr[log2(DEPTH)+log2(W_DATA/8)-1 : log2(W_DATA/8)]; no wrap-around, out-of-range errors instead.
- Request changes during a wait state are ignored; the request is latched at capture.

Optional Feature:
- Macro AHBL_SRAM_RAND_STALL_EN.
- Defined:
  - An 8-bit Galois LFSR (taps 0xB8, seed 0x01 on reset) steps every cycle.
  - At capture of an in-range transfer, LFSR[1:0] extra wait states are added to the configured count.
  - The ERROR sequence is unaffected.
- Undefined: wait counts are exactly NSEQ_WAIT/SEQ_WAIT and no LFSR logic exists.

Decomposition:
- Shared package ahbl_pkg:
  - HTRANS codes (IDLE=0, BUSY=1, NSEQ=2, SEQ=3).
  - HSIZE codes (BYTE=0, HALF=1, WORD=2, DWORD=3).
  - HRESP codes (OKAY=0, ERROR=1).
  - FSM state enum for this block.
- Sub-module ahbl_sram_stall_lfsr: the LFSR, instantiated only under AHBL_SRAM_RAND_STALL_EN.
- Strobe decode and forwarding stay inline.

Test Plan:
- Reset then IDLE address phases for 4 cycles → hready_resp=1, hresp=0 every cycle, hrdata=0.
- NSEQ word write 0xDEADBEEF to 0x10 (NSEQ_WAIT=1), then NSEQ word read of 0x10:
  - Each data phase is 1 wait cycle then completion.
  - Read returns 0xDEADBEEF.
- Byte write 0xAA to 0x13, then word read of 0x10 → 0xAAADBEEF.
- Word write 0x12345678 to 0x20 immediately followed by a read of 0x20 with NSEQ_WAIT=0 → read returns 0x12345678 via forwarding.
- INCR4 burst (NSEQ + 3 SEQ) reading 0x00–0x0C with SEQ_WAIT=0:
  - Beats complete on consecutive cycles after the NSEQ wait.
  - Data matches memory.
- Read of address DEPTH*W_DATA/8:
  - Cycle 1: hready_resp=0, hresp=1.
  - Cycle 2: hready_resp=1, hresp=1.
  - A following write to 0x40 is an ERROR and leaves memory unchanged.
